trap_seq: RTL and testbench
===========================

Name: trap_seq

Overview:
- Multi-cycle trap controller sitting between the decode stage, the pipeline ctrl block and csr_regs.
- Detects ecall, ebreak and mret at the ID stage, and gated machine-timer interrupts.
- Arbitrates the single CSR write port, sequencing mepc, mcause and mstatus updates one per cycle.
- Holds the pipeline while busy, then issues one redirect pulse to ctrl.

Parameters:
- XLEN, 64, data width of CSR values and PCs.
- TIMER_CAUSE, 7, interrupt cause code for the machine timer.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- inst_i  in  32  instruction in ID.
- inst_addr_i  in  XLEN  PC of inst_i.
- inst_valid_i  in  1  inst_i is a real instruction, not a bubble.
- mtvec_i  in  XLEN  current mtvec.
- mepc_i  in  XLEN  current mepc.
- mstatus_i  in  XLEN  current mstatus.
- mie_i  in  XLEN  current mie.
- timer_irq_i  in  1  level timer pending (mtime >= mtimecmp).
- stall_o  out  1  freeze IF/ID (combinational).
- busy_o  out  1  FSM not IDLE (registered).
- csr_wen_o  out  1  CSR write strobe (registered).
- csr_waddr_o  out  12  CSR address.
- csr_wdata_o  out  XLEN  CSR data.
- intr_jump_en_o  out  1  one-cycle redirect pulse (registered).
- intr_jump_addr_o  out  XLEN  redirect target.
- halt_o  out  1  simulation halt; only meaningful with the optional feature, otherwise tied 0.

Behaviour:
- Reset
  - rst==0 at a clock edge: state goes to IDLE.
  - All registered outputs go to 0, capture registers are cleared.
  - Applies in any state; an in-flight sequence is abandoned, with no partial jump.
- Trap detection, combinational, in IDLE only with inst_valid_i==1:
  - irq = timer_irq_i & mstatus_i[3] & mie_i[7].
  - Priority: irq > ecall > ebreak > mret. An interrupt coinciding with ecall wins; the ecall re-executes after return.
- stall_o = (state!=IDLE) | (IDLE & a trap detected).
- On detection, capture in one cycle:
  - pc, from inst_addr_i.
  - cause:
    - irq: {1, TIMER_CAUSE}.
    - ecall: 11.
    - ebreak: 3.
  - mstatus_i and the target address.
- Trap entry target:
  - mtvec_i[1:0]==1 and irq: {mtvec[XLEN-1:2],00} + 4*cause[XLEN-2:0], truncated to XLEN.
  - Otherwise: {mtvec[XLEN-1:2],00}.
- mret target: mepc_i, unmodified; software handles +4.
- FSM states: IDLE, W_MEPC, W_CAUSE, W_STAT, JUMP.
  - Entry (irq, ecall, ebreak): IDLE -> W_MEPC -> W_CAUSE -> W_STAT -> JUMP -> IDLE.
  - mret: IDLE -> W_STAT -> JUMP -> IDLE.
- Output timing
  - Outputs are registered, so a write or jump is visible in the cycle after its state is entered.
  - With detection in cycle N, entry produces:
    - N+1: csr_wen=1, addr 0x341, data pc.
    - N+2: addr 0x342, data cause.
    - N+3: addr 0x300, data new mstatus.
    - N+4: intr_jump_en=1 with target.
    - N+5: IDLE, outputs 0.
  - mret produces the mstatus write at N+1 and the jump at N+2.
- busy_o is high from N+1 through the jump cycle.
- mstatus update on entry:
  - MPIE[7] = old MIE[3].
  - MIE = 0.
  - MPP[12:11] = 11.
  - Other bits unchanged.
- mstatus update on mret:
  - MIE = old MPIE.
  - MPIE = 1.
  - MPP = 00.
  - Other bits unchanged.
- All values are taken from the captured copy; input changes during the sequence (irq drop, PC change) have no effect.
- inst_i and timer_irq_i are ignored outside IDLE.
- Back-to-back: a trap presented in the cycle of return to IDLE (N+5 for entry, N+3 for mret) is accepted.
- Unused csr_waddr_o/csr_wdata_o are 0 when csr_wen_o==0.
- intr_jump_addr_o is 0 when intr_jump_en_o==0.

Optional Feature:
- Macro: TRAP_EBREAK_HALT_EN.
- Defined:
  - ebreak is not a trap.
  - IDLE -> HALT; halt_o goes to 1 at N+1, stall_o holds 1, and no CSR writes occur.
  - HALT is left only by reset.
  - The sim harness ends on halt_o.
- Undefined:
  - halt_o tied 0.
  - ebreak is a normal cause-3 trap.

Test Plan:
- ecall at pc 0x80000010, mtvec 0x80000100, mstatus 0x8 -> N+1 write 0x341=0x80000010; N+2 0x342=11; N+3 0x300=0x1880; N+4 jump 0x80000100; stall_o high N..N+4.
- mret with mepc 0x80000014, mstatus 0x1880 -> N+1 write 0x300=0x88; N+2 jump 0x80000014; no mepc/mcause write.
- timer_irq=1, mie 0x80, mstatus 0x8, mtvec 0x80000101, inst at 0x80000020 -> mcause 0x8000000000000007, mepc 0x80000020, jump 0x8000011C.
- timer_irq=1 with mstatus MIE=0 -> no stall, no writes; the same cycle with ecall gives an ecall trap to cause 11.
- irq and ecall together at pc 0x80000040 -> interrupt wins: mcause 0x8000000000000007, mepc 0x80000040.
- ecall, then rst=0 at N+2 -> N+3 all outputs 0, state IDLE, no jump pulse ever; ebreak without the macro gives mcause 3; with the macro, halt_o=1 at N+1 and stays.

Source files
------------

// File: rtl/trap_seq.sv
// Trap sequencer: detects ecall/ebreak/mret/timer interrupt at ID, writes mepc/mcause/mstatus, then redirects.
// Optional TRAP_EBREAK_HALT_EN: ebreak parks the FSM in HALT and raises halt_o until reset.
module trap_seq #(
  parameter int XLEN        = 64,
  parameter int TIMER_CAUSE = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic            inst_valid_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic            timer_irq_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            csr_wen_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            intr_jump_en_o,
  output logic [XLEN-1:0] intr_jump_addr_o,
  output logic            halt_o
);

  localparam logic [31:0]     INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0]     INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0]     INST_MRET   = 32'h3020_0073;
  localparam logic [11:0]     CSR_MSTATUS = 12'h300;
  localparam logic [11:0]     CSR_MEPC    = 12'h341;
  localparam logic [11:0]     CSR_MCAUSE  = 12'h342;
  localparam logic [XLEN-1:0] IRQ_CAUSE   = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(TIMER_CAUSE);
  localparam logic [XLEN-1:0] VEC_OFFSET  = {IRQ_CAUSE[XLEN-3:0], 2'b00};

  typedef enum logic [2:0] {IDLE, W_MEPC, W_CAUSE, W_STAT, JUMP, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            busy_q;
  logic            csr_wen_q, csr_wen_d;
  logic [11:0]     csr_waddr_q, csr_waddr_d;
  logic [XLEN-1:0] csr_wdata_q, csr_wdata_d;
  logic            jump_en_q, jump_en_d;
  logic [XLEN-1:0] jump_addr_q, jump_addr_d;

  logic            idle, irq;
  logic            take_irq, take_ecall, take_ebreak, take_mret, take_halt, take_entry;
  logic [XLEN-1:0] mtvec_base, entry_target, entry_mstatus, mret_mstatus;
  logic            unused_mie;

  assign unused_mie = ^{mie_i[XLEN-1:8], mie_i[6:0]};

  assign idle        = (state_q == IDLE);
  assign irq         = timer_irq_i & mstatus_i[3] & mie_i[7];
  assign take_irq    = idle & inst_valid_i & irq;
  assign take_ecall  = idle & inst_valid_i & ~irq & (inst_i == INST_ECALL);
  assign take_mret   = idle & inst_valid_i & ~irq & (inst_i == INST_MRET);
`ifdef TRAP_EBREAK_HALT_EN
  assign take_ebreak = 1'b0;
  assign take_halt   = idle & inst_valid_i & ~irq & (inst_i == INST_EBREAK);
  assign halt_o      = (state_q == HALT);
`else
  assign take_ebreak = idle & inst_valid_i & ~irq & (inst_i == INST_EBREAK);
  assign take_halt   = 1'b0;
  assign halt_o      = 1'b0;
`endif
  assign take_entry  = take_irq | take_ecall | take_ebreak;

  assign stall_o = ~idle | take_entry | take_mret | take_halt;

  // Vectored mode only offsets asynchronous interrupts; exceptions always land on the base.
  assign mtvec_base   = {mtvec_i[XLEN-1:2], 2'b00};
  assign entry_target = ((mtvec_i[1:0] == 2'b01) && take_irq) ? mtvec_base + VEC_OFFSET : mtvec_base;

  always_comb begin
    entry_mstatus        = mstatus_i;
    entry_mstatus[7]     = mstatus_i[3];
    entry_mstatus[3]     = 1'b0;
    entry_mstatus[12:11] = 2'b11;
    mret_mstatus         = mstatus_i;
    mret_mstatus[3]      = mstatus_i[7];
    mret_mstatus[7]      = 1'b1;
    mret_mstatus[12:11]  = 2'b00;
  end

  // Outputs are computed for the state being entered, so they appear with that state.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    mstatus_d   = mstatus_q;
    target_d    = target_q;
    csr_wen_d   = 1'b0;
    csr_waddr_d = '0;
    csr_wdata_d = '0;
    jump_en_d   = 1'b0;
    jump_addr_d = '0;
    case (state_q)
      IDLE: begin
        if (take_halt) begin
          state_d = HALT;
        end else if (take_entry) begin
          state_d     = W_MEPC;
          cause_d     = take_irq ? IRQ_CAUSE : (take_ecall ? XLEN'(11) : XLEN'(3));
          mstatus_d   = entry_mstatus;
          target_d    = entry_target;
          csr_wen_d   = 1'b1;
          csr_waddr_d = CSR_MEPC;
          csr_wdata_d = inst_addr_i;
        end else if (take_mret) begin
          state_d     = W_STAT;
          target_d    = mepc_i;
          csr_wen_d   = 1'b1;
          csr_waddr_d = CSR_MSTATUS;
          csr_wdata_d = mret_mstatus;
        end
      end
      W_MEPC: begin
        state_d     = W_CAUSE;
        csr_wen_d   = 1'b1;
        csr_waddr_d = CSR_MCAUSE;
        csr_wdata_d = cause_q;
      end
      W_CAUSE: begin
        state_d     = W_STAT;
        csr_wen_d   = 1'b1;
        csr_waddr_d = CSR_MSTATUS;
        csr_wdata_d = mstatus_q;
      end
      W_STAT: begin
        state_d     = JUMP;
        jump_en_d   = 1'b1;
        jump_addr_d = target_q;
      end
      JUMP:    state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cause_q     <= '0;
      mstatus_q   <= '0;
      target_q    <= '0;
      busy_q      <= 1'b0;
      csr_wen_q   <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      mstatus_q   <= mstatus_d;
      target_q    <= target_d;
      busy_q      <= (state_d != IDLE);
      csr_wen_q   <= csr_wen_d;
      csr_waddr_q <= csr_waddr_d;
      csr_wdata_q <= csr_wdata_d;
      jump_en_q   <= jump_en_d;
      jump_addr_q <= jump_addr_d;
    end
  end

  assign busy_o           = busy_q;
  assign csr_wen_o        = csr_wen_q;
  assign csr_waddr_o      = csr_waddr_q;
  assign csr_wdata_o      = csr_wdata_q;
  assign intr_jump_en_o   = jump_en_q;
  assign intr_jump_addr_o = jump_addr_q;

endmodule

// File: tb/tb_trap_seq.sv
// Bench for trap_seq: directed test-plan cases, mid-sequence reset, then random traps against a rule-level model.
module tb_trap_seq;
  localparam int          XLEN   = 64;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [63:0] IRQ_CAUSE = 64'h8000_0000_0000_0007;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [31:0]     inst_i = NOP;
  logic [XLEN-1:0] inst_addr_i = '0;
  logic            inst_valid_i = 1'b0;
  logic [XLEN-1:0] mtvec_i = '0, mepc_i = '0, mstatus_i = '0, mie_i = '0;
  logic            timer_irq_i = 1'b0;
  logic            stall_o, busy_o, csr_wen_o, intr_jump_en_o, halt_o;
  logic [11:0]     csr_waddr_o;
  logic [XLEN-1:0] csr_wdata_o, intr_jump_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  trap_seq #(.XLEN(XLEN), .TIMER_CAUSE(7)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .inst_valid_i(inst_valid_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .mstatus_i(mstatus_i), .mie_i(mie_i), .timer_irq_i(timer_irq_i),
    .stall_o(stall_o), .busy_o(busy_o), .csr_wen_o(csr_wen_o),
    .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .intr_jump_en_o(intr_jump_en_o), .intr_jump_addr_o(intr_jump_addr_o),
    .halt_o(halt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                       input logic [63:0] tvec, input logic [63:0] epc,
                       input logic [63:0] ms, input logic [63:0] ie, input logic tirq);
    inst_valid_i = v;    inst_i = inst;  inst_addr_i = pc;
    mtvec_i = tvec;      mepc_i = epc;   mstatus_i = ms;
    mie_i = ie;          timer_irq_i = tirq;
  endtask

  task automatic bubble();
    inst_valid_i = 1'b0;
    timer_irq_i  = 1'b0;
  endtask

  // Inputs that would trap if sampled in IDLE; used while busy to show they are ignored.
  task automatic scramble();
    drive(1'b1, ECALL, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom} | 64'h8, 64'h80, 1'b1);
  endtask

  task automatic expect_out(input string tag, input logic wen, input logic [11:0] addr,
                            input logic [63:0] data, input logic jen, input logic [63:0] jaddr,
                            input logic busy);
    $display("[%0t] %s: wen=%0b addr=%h data=%h jump=%0b jaddr=%h busy=%0b stall=%0b",
             $time, tag, csr_wen_o, csr_waddr_o, csr_wdata_o, intr_jump_en_o,
             intr_jump_addr_o, busy_o, stall_o);
    chk({tag, ".wen"},   csr_wen_o,        wen);
    chk({tag, ".addr"},  csr_waddr_o,      addr);
    chk({tag, ".data"},  csr_wdata_o,      data);
    chk({tag, ".jen"},   intr_jump_en_o,   jen);
    chk({tag, ".jaddr"}, intr_jump_addr_o, jaddr);
    chk({tag, ".busy"},  busy_o,           busy);
    chk({tag, ".stall"}, stall_o,          busy);
    chk({tag, ".halt"},  halt_o,           1'b0);
  endtask

  // Called in detection cycle N (inputs applied, stall already checked); returns in N+5 (or N+3) with a bubble.
  task automatic expect_seq(input string tag, input logic is_mret, input logic [63:0] pc,
                            input logic [63:0] cause, input logic [63:0] ms, input logic [63:0] tgt);
    tick();
    if (!is_mret) begin
      expect_out({tag, ".mepc"}, 1'b1, 12'h341, pc, 1'b0, 64'h0, 1'b1);
      scramble();
      tick();
      expect_out({tag, ".mcause"}, 1'b1, 12'h342, cause, 1'b0, 64'h0, 1'b1);
      tick();
    end else begin
      scramble();
    end
    expect_out({tag, ".mstatus"}, 1'b1, 12'h300, ms, 1'b0, 64'h0, 1'b1);
    tick();
    expect_out({tag, ".jump"}, 1'b0, 12'h0, 64'h0, 1'b1, tgt, 1'b1);
    bubble();
    tick();
    expect_out({tag, ".idle"}, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0, 1'b0);
  endtask

  // Reference model: kind 0 = nothing, 1 = trap entry, 2 = mret.
  task automatic model(input logic v, input logic [31:0] inst, input logic [63:0] tvec,
                       input logic [63:0] epc, input logic [63:0] ms, input logic [63:0] ie,
                       input logic tirq, output int kind, output logic [63:0] cause,
                       output logic [63:0] ms_new, output logic [63:0] tgt);
    logic        irq;
    logic [63:0] keep, base;
    irq  = tirq && ms[3] && ie[7];
    kind = 0; cause = 0; ms_new = 0; tgt = 0;
    if (v) begin
      if (irq)                 begin kind = 1; cause = IRQ_CAUSE; end
      else if (inst == ECALL)  begin kind = 1; cause = 11; end
      else if (inst == EBREAK) begin kind = 1; cause = 3; end
      else if (inst == MRET)   kind = 2;
    end
    keep = ms & ~64'h1888;
    base = tvec - (tvec % 4);
    if (kind == 1) begin
      ms_new = keep | (ms[3] ? 64'h80 : 64'h0) | 64'h1800;
      tgt    = (irq && (tvec % 4 == 1)) ? base + 4 * (cause - 64'h8000_0000_0000_0000) : base;
    end else if (kind == 2) begin
      ms_new = keep | (ms[7] ? 64'h8 : 64'h0) | 64'h80;
      tgt    = epc;
    end
  endtask

  initial begin
    int          kind;
    logic [63:0] cause, ms_new, tgt;
    logic [31:0] inst;
    logic [63:0] pc, tvec, epc, ms, ie;
    logic        v, tirq;

    rst = 1'b0;
    repeat (3) tick();
    expect_out("reset", 1'b0, 12'h0, 64'h0, 1'b0, 64'h0, 1'b0);
    rst = 1'b1;
    tick();

    drive(1'b1, ECALL, 64'h8000_0010, 64'h8000_0100, 64'h0, 64'h8, 64'h0, 1'b0);
    #1 chk("ecall.stall_n", stall_o, 1'b1);
    expect_seq("ecall", 1'b0, 64'h8000_0010, 64'd11, 64'h1880, 64'h8000_0100);

    drive(1'b1, MRET, 64'h8000_0030, 64'h8000_0100, 64'h8000_0014, 64'h1880, 64'h0, 1'b0);
    #1 chk("mret.stall_n", stall_o, 1'b1);
    expect_seq("mret", 1'b1, 64'h0, 64'h0, 64'h88, 64'h8000_0014);

    drive(1'b1, NOP, 64'h8000_0020, 64'h8000_0101, 64'h0, 64'h8, 64'h80, 1'b1);
    #1 chk("irq_vec.stall_n", stall_o, 1'b1);
    expect_seq("irq_vec", 1'b0, 64'h8000_0020, IRQ_CAUSE, 64'h1880, 64'h8000_011C);

    drive(1'b1, NOP, 64'h8000_0024, 64'h8000_0101, 64'h0, 64'h0, 64'h80, 1'b1);
    #1 chk("irq_masked.stall_n", stall_o, 1'b0);
    tick();
    expect_out("irq_masked", 1'b0, 12'h0, 64'h0, 1'b0, 64'h0, 1'b0);
    inst_i = ECALL;
    #1 chk("masked_ecall.stall_n", stall_o, 1'b1);
    expect_seq("masked_ecall", 1'b0, 64'h8000_0024, 64'd11, 64'h1800, 64'h8000_0100);

    drive(1'b1, ECALL, 64'h8000_0040, 64'h8000_0100, 64'h0, 64'h8, 64'h80, 1'b1);
    #1 chk("irq_ecall.stall_n", stall_o, 1'b1);
    expect_seq("irq_ecall", 1'b0, 64'h8000_0040, IRQ_CAUSE, 64'h1880, 64'h8000_0100);

`ifndef TRAP_EBREAK_HALT_EN
    drive(1'b1, EBREAK, 64'h8000_0050, 64'h8000_0200, 64'h0, 64'h0, 64'h0, 1'b0);
    #1 chk("ebreak.stall_n", stall_o, 1'b1);
    expect_seq("ebreak", 1'b0, 64'h8000_0050, 64'd3, 64'h1800, 64'h8000_0200);
`endif

    drive(1'b1, ECALL, 64'h8000_0060, 64'h8000_0100, 64'h0, 64'h8, 64'h0, 1'b0);
    tick();
    expect_out("rst_mid.mepc", 1'b1, 12'h341, 64'h8000_0060, 1'b0, 64'h0, 1'b1);
    tick();
    bubble();
    rst = 1'b0;
    tick();
    expect_out("rst_mid.cleared", 1'b0, 12'h0, 64'h0, 1'b0, 64'h0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("rst_mid.quiet", 1'b0, 12'h0, 64'h0, 1'b0, 64'h0, 1'b0);
    end
    drive(1'b1, MRET, 64'h8000_0070, 64'h0, 64'h8000_0064, 64'h80, 64'h0, 1'b0);
    #1 chk("post_rst.stall_n", stall_o, 1'b1);
    expect_seq("post_rst_mret", 1'b1, 64'h0, 64'h0, 64'h88, 64'h8000_0064);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: inst = ECALL;
        1: inst = EBREAK;
        2: inst = MRET;
        3: inst = NOP;
        default: inst = $urandom;
      endcase
`ifdef TRAP_EBREAK_HALT_EN
      if (inst == EBREAK) inst = NOP;
`endif
      v    = ($urandom_range(0, 7) != 0);
      pc   = {$urandom, $urandom};
      tvec = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) tvec[1:0] = 2'b01;
      epc  = {$urandom, $urandom};
      ms   = {$urandom, $urandom};
      ie   = {$urandom, $urandom};
      tirq = $urandom_range(0, 1) == 1;
      model(v, inst, tvec, epc, ms, ie, tirq, kind, cause, ms_new, tgt);
      drive(v, inst, pc, tvec, epc, ms, ie, tirq);
      #1 chk("rand.stall_n", stall_o, kind != 0);
      if (kind == 0) begin
        tick();
        expect_out("rand.none", 1'b0, 12'h0, 64'h0, 1'b0, 64'h0, 1'b0);
        bubble();
      end else begin
        expect_seq("rand", kind == 2, pc, cause, ms_new, tgt);
      end
    end

`ifdef TRAP_EBREAK_HALT_EN
    drive(1'b1, EBREAK, 64'h8000_0080, 64'h8000_0100, 64'h0, 64'h8, 64'h0, 1'b0);
    #1 chk("halt.stall_n", stall_o, 1'b1);
    tick();
    bubble();
    for (int i = 0; i < 5; i++) begin
      $display("[%0t] halt: halt=%0b wen=%0b jump=%0b stall=%0b", $time, halt_o, csr_wen_o,
               intr_jump_en_o, stall_o);
      chk("halt.halt", halt_o, 1'b1);
      chk("halt.wen", csr_wen_o, 1'b0);
      chk("halt.jump", intr_jump_en_o, 1'b0);
      chk("halt.stall", stall_o, 1'b1);
      tick();
    end
    rst = 1'b0;
    tick();
    chk("halt.reset", halt_o, 1'b0);
    rst = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
